// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, runs one req/gnt/rvalid fetch at a time and
// buffers the returned word for decode. Optional misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module fetch_seq #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    input  logic        if_ready_i,
    input  logic        redirect_valid_i,
    input  logic [1:0]  npc_op_i,
    input  logic [31:0] redir_pc_i,
    input  logic [25:0] imm_i,
    input  logic [31:0] pcjr_i,
    output logic        misalign_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;
    localparam logic [1:0] StHold = 2'd3;

    localparam logic [1:0] NpcPlus4  = 2'b00;
    localparam logic [1:0] NpcBranch = 2'b01;
    localparam logic [1:0] NpcJump   = 2'b10;
    localparam logic [1:0] NpcJumpR  = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        target_mis;
    logic        redirect;

    always_comb begin
        pc_plus4   = redir_pc_i + 32'd4;
        br_off     = {{14{imm_i[15]}}, imm_i[15:0], 2'b00};
        target_raw = pc_plus4;
        case (npc_op_i)
            NpcPlus4:  target_raw = pc_plus4;
            NpcBranch: target_raw = pc_plus4 + br_off;
            NpcJump:   target_raw = {pc_plus4[31:28], imm_i, 2'b00};
            NpcJumpR:  target_raw = pcjr_i;
            default:   target_raw = pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_mis = |target_raw[1:0];
    assign target     = target_mis ? EXC_VECTOR : target_raw;
`else
    // Without the trap, a misaligned target is silently rounded down to a word boundary.
    assign target_mis = 1'b0;
    assign target     = {target_raw[31:2], 2'b00};
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    assign redirect = redirect_valid_i && (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        misalign_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d    = StReq;
                fetch_pc_d = RESET_PC;
                kill_d     = 1'b0;
            end
            StReq: begin
                // A granted request on the old path must still be drained, so mark it killed.
                if (imem_gnt_i) begin
                    state_d = StResp;
                    kill_d  = redirect;
                end
            end
            StResp: begin
                if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect) begin
                        state_d = StReq;
                    end else begin
                        state_d = StHold;
                        instr_d = imem_rdata_i;
                        if_pc_d = fetch_pc_q;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect) begin
                    state_d = StReq;
                end else if (if_ready_i) begin
                    state_d    = StReq;
                    fetch_pc_d = if_pc_q + 32'd4;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect) begin
            fetch_pc_d = target;
            misalign_d = target_mis;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= 32'd0;
            if_pc_q    <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            if_pc_q    <= if_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req_o  = (state_q == StReq);
    assign imem_addr_o = fetch_pc_q;
    assign if_valid_o  = (state_q == StHold);
    assign if_instr_o  = instr_q;
    assign if_pc_o     = if_pc_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed test-plan steps followed by randomized traffic, all checked
// against a behavioural model of the fetch stream and a hashed instruction memory.
module tb_fetch_seq;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic [31:0] redir_pc = 32'd0;
    logic [25:0] imm = 26'd0;
    logic [31:0] pcjr = 32'd0;
    logic        misalign_o;

    always #5 clk = ~clk;

    fetch_seq dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .if_valid_o       (if_valid_o),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .if_ready_i       (if_ready),
        .redirect_valid_i (redirect_valid),
        .npc_op_i         (npc_op),
        .redir_pc_i       (redir_pc),
        .imm_i            (imm),
        .pcjr_i           (pcjr),
        .misalign_o       (misalign_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned gnt_pct = 100;
    int unsigned rv_pct  = 100;
    bit          rand_mode = 1'b0;
    bit          force_rv  = 1'b0;

    // Instruction memory: at most one granted request outstanding.
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'd0;

    // Reference model of the fetch stream.
    bit          m_idle = 1'b1, m_asking = 1'b0, m_waiting = 1'b0, m_have = 1'b0;
    bit          m_drop = 1'b0, m_mis = 1'b0;
    logic [31:0] m_pc = RESET_PC, m_instr = 32'd0, m_ipc = RESET_PC;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Returns {misaligned, next fetch address} for a redirect.
    function automatic logic [32:0] ref_target(input logic [1:0] op, input logic [31:0] rpc,
                                               input logic [25:0] im, input logic [31:0] jr);
        logic [31:0] nxt, t;
        int          off;
        nxt = rpc + 32'd4;
        case (op)
            2'd0: t = nxt;
            2'd1: begin
                off = int'($signed(im[15:0]));
                t   = nxt + 32'(off * 4);
            end
            2'd2: t = (nxt & 32'hF000_0000) + (32'(im) * 32'd4);
            default: t = jr;
        endcase
        if (TRAP && (t % 4 != 0)) return {1'b1, EXC_VECTOR};
        return {1'b0, t - (t % 4)};
    endfunction

    task automatic model_step();
        logic [32:0] r;
        bit          redir;
        if (!rstn) begin
            m_idle = 1'b1; m_asking = 1'b0; m_waiting = 1'b0; m_have = 1'b0;
            m_drop = 1'b0; m_mis = 1'b0;
            m_pc = RESET_PC; m_instr = 32'd0; m_ipc = RESET_PC;
            return;
        end
        r     = ref_target(npc_op, redir_pc, imm, pcjr);
        redir = redirect_valid && !m_idle;
        m_mis = 1'b0;
        if (m_idle) begin
            m_idle = 1'b0; m_asking = 1'b1; m_pc = RESET_PC;
        end else if (m_asking) begin
            if (imem_gnt) begin
                m_asking = 1'b0; m_waiting = 1'b1; m_drop = redir;
            end
        end else if (m_waiting) begin
            if (imem_rvalid) begin
                m_waiting = 1'b0;
                if (redir || m_drop) begin
                    m_asking = 1'b1; m_drop = 1'b0;
                end else begin
                    m_have = 1'b1; m_instr = imem_rdata; m_ipc = m_pc;
                end
            end else if (redir) begin
                m_drop = 1'b1;
            end
        end else if (m_have) begin
            if (redir || if_ready) begin
                m_have = 1'b0; m_asking = 1'b1;
                if (!redir) m_pc = m_ipc + 32'd4;
            end
        end
        if (redir) begin
            m_pc  = r[31:0];
            m_mis = r[32];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("model_req",      32'(imem_req_o), 32'(m_asking));
        check("model_addr",     imem_addr_o,     m_pc);
        check("model_valid",    32'(if_valid_o), 32'(m_have));
        check("model_instr",    if_instr_o,      m_instr);
        check("model_pc",       if_pc_o,         m_ipc);
        check("model_misalign", 32'(misalign_o), 32'(m_mis));
    endtask

    task automatic tick();
        logic [31:0] addr_s;
        if (rand_mode) begin
            rstn           = ($urandom_range(99) != 0);
            if_ready       = ($urandom_range(9) < 7);
            redirect_valid = ($urandom_range(9) == 0);
            npc_op         = 2'($urandom);
            redir_pc       = $urandom & 32'hFFFF_FFFC;
            imm            = 26'($urandom);
            pcjr           = $urandom_range(1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
        end
        imem_gnt    = (imem_req_o === 1'b1) && ($urandom_range(99) < gnt_pct);
        imem_rvalid = force_rv || (mem_pend && ($urandom_range(99) < rv_pct));
        imem_rdata  = imem_rvalid ? word(mem_addr) : $urandom;
        addr_s      = imem_addr_o;
        @(posedge clk);
        model_step();
        if (!rstn) begin
            mem_pend = 1'b0;
        end else begin
            if (imem_rvalid) mem_pend = 1'b0;
            if (imem_gnt) begin
                mem_pend = 1'b1;
                mem_addr = addr_s;
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        // Reset values.
        rstn = 1'b0;
        repeat (3) tick();
        check("rst_req",   32'(imem_req_o), 32'd0);
        check("rst_addr",  imem_addr_o,     RESET_PC);
        check("rst_valid", 32'(if_valid_o), 32'd0);
        check("rst_instr", if_instr_o,      32'd0);
        check("rst_pc",    if_pc_o,         RESET_PC);
        check("rst_mis",   32'(misalign_o), 32'd0);

        // Zero-wait memory: one instruction every three cycles.
        rstn = 1'b1;
        if_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("seq_req",  32'(imem_req_o), 32'd1);
            check("seq_addr", imem_addr_o,     RESET_PC + 32'(4 * i));
            tick();
            tick();
            check("seq_valid", 32'(if_valid_o), 32'd1);
            check("seq_pc",    if_pc_o,         RESET_PC + 32'(4 * i));
            check("seq_instr", if_instr_o,      word(RESET_PC + 32'(4 * i)));
            tick();
        end

        // Decode stall in HOLD.
        if_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(if_valid_o), 32'd1);
            check("stall_instr", if_instr_o,      word(32'h0000_300C));
            check("stall_req",   32'(imem_req_o), 32'd0);
            tick();
        end
        if_ready = 1'b1;
        tick();
        check("release_req",  32'(imem_req_o), 32'd1);
        check("release_addr", imem_addr_o,     32'h0000_3010);

        // Branch redirect while the response is in flight; rvalid lands in the same cycle.
        tick();
        redirect_valid = 1'b1; npc_op = 2'b01; redir_pc = 32'h0000_3010; imm = 26'h000_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("br_req",   32'(imem_req_o), 32'd1);
        check("br_addr",  imem_addr_o,     32'h0000_3004);
        check("br_valid", 32'(if_valid_o), 32'd0);

        // Jump redirect in HOLD wins over if_ready.
        tick();
        tick();
        check("j_hold", 32'(if_valid_o), 32'd1);
        redirect_valid = 1'b1; npc_op = 2'b10; redir_pc = 32'h0000_3004; imm = 26'h000_0C40;
        tick();
        redirect_valid = 1'b0;
        check("j_valid", 32'(if_valid_o), 32'd0);
        check("j_req",   32'(imem_req_o), 32'd1);
        check("j_addr",  imem_addr_o,     32'h0000_3100);

        // Register jump to a misaligned target while REQ is not granted.
        gnt_pct = 0;
        redirect_valid = 1'b1; npc_op = 2'b11; pcjr = 32'h0000_3402;
        tick();
        redirect_valid = 1'b0;
        check("jr_addr", imem_addr_o, TRAP ? 32'h0000_4180 : 32'h0000_3400);
        check("jr_mis",  32'(misalign_o), 32'(TRAP));
        tick();
        check("jr_mis_end", 32'(misalign_o), 32'd0);
        check("jr_req",     32'(imem_req_o), 32'd1);
        gnt_pct = 100;

        // Reset in RESP with a stale rvalid during and just after reset.
        tick();
        rstn = 1'b0; force_rv = 1'b1;
        tick();
        check("mid_rst_valid", 32'(if_valid_o), 32'd0);
        check("mid_rst_req",   32'(imem_req_o), 32'd0);
        check("mid_rst_instr", if_instr_o,      32'd0);
        check("mid_rst_addr",  imem_addr_o,     RESET_PC);
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_req",   32'(imem_req_o), 32'd1);
        check("post_rst_addr",  imem_addr_o,     RESET_PC);
        check("post_rst_valid", 32'(if_valid_o), 32'd0);
        force_rv = 1'b0;
        tick();
        tick();
        check("post_rst_pc",    if_pc_o,    RESET_PC);
        check("post_rst_instr", if_instr_o, word(RESET_PC));

        // Randomized traffic: stalls, redirects, slow memory, occasional reset.
        gnt_pct   = 60;
        rv_pct    = 50;
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
